// File: rtl/rf_pkg.sv
// Shared definitions for the pipelined-core register file.
// Defaults: XLEN_D data width, NREGS_D register count, AW_D address width.
// rf_rst_val gives the reset image of one register.
package rf_pkg;

  localparam int unsigned XLEN_D  = 32;
  localparam int unsigned NREGS_D = 32;
  localparam int unsigned AW_D    = $clog2(NREGS_D);

  typedef logic [XLEN_D-1:0] rf_word_t;
  typedef logic [AW_D-1:0]   rf_addr_t;

  // Legacy bring-up images preload reg[i] = i. Register 0 is always 0.
  function automatic int unsigned rf_rst_val(input int unsigned idx, input bit rst_idx);
    return (rst_idx && (idx != 0)) ? idx : 0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used for hazard detection.
// Ports: clk, rst_n (async active-low), i_clr_en/i_clr_addr (writeback clears),
//        i_set_en/i_set_addr (issue reserves), o_busy (all busy bits),
//        o_all_clear (no register busy).
// A set and a clear on the same register in one cycle leave it busy:
// the new producer wins. Register 0 can never become busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_D,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr_en,
  input  logic [AW-1:0]    i_clr_addr,
  input  logic             i_set_en,
  input  logic [AW-1:0]    i_set_addr,
  output logic [NREGS-1:0] o_busy,
  output logic             o_all_clear
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy state: clear first, then set so the set takes priority.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en && (i_clr_addr != '0)) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en && (i_set_addr != '0)) w_busy_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy      = r_busy;
  assign o_all_clear = ~|r_busy;

endmodule

// File: rtl/pipe_reg_file.sv
// Register file for the pipelined core: NRD combinational read ports, one
// synchronous write port, and a busy scoreboard for in-flight producers.
// Ports: clk, rst_n (async active-low), rd_addr/rd_data/rd_busy (packed per port),
//        wr_en/wr_addr/wr_data (writeback), rsv_en/rsv_addr (issue reservation),
//        all_clear (no register busy).
// Optional feature macro: RF_BYPASS_EN enables write-through forwarding of the
// write port onto matching read ports in the same cycle.
module pipe_reg_file
  import rf_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_D,
  parameter int unsigned NREGS   = NREGS_D,
  parameter int unsigned NRD     = 2,
  parameter int unsigned RST_IDX = 0,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                all_clear
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  // Storage; register 0 is never written and is masked on read as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        r_regs[i] <= XLEN'(rf_rst_val(i, RST_IDX != 0));
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_en   (wr_en),
    .i_clr_addr (wr_addr),
    .i_set_en   (rsv_en),
    .i_set_addr (rsv_addr),
    .o_busy     (w_busy),
    .o_all_clear(all_clear)
  );

  // Independent read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_data;
    logic            w_bsy;

    assign w_ra = rd_addr[k*AW +: AW];

    always_comb begin
      w_data = (w_ra == '0) ? '0 : r_regs[w_ra];
      w_bsy  = w_busy[w_ra];
`ifdef RF_BYPASS_EN
      // The value being written this cycle is already final, so it is not busy.
      if (wr_en && (wr_addr == w_ra) && (wr_addr != '0)) begin
        w_data = wr_data;
        w_bsy  = 1'b0;
      end
`endif
    end

    assign rd_data[k*XLEN +: XLEN] = w_data;
    assign rd_busy[k]              = w_bsy;
  end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Scoreboard bench for pipe_reg_file: two instances (RST_IDX=1 and RST_IDX=0)
// share all inputs; stimulus pushes expected port values, a negedge monitor
// pops and compares them.
module tb_pipe_reg_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                rsv_en = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;

  logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]      rd_busy_a, rd_busy_b;
  logic                all_clear_a, all_clear_b;

  always #5 clk = ~clk;

  pipe_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .RST_IDX(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .all_clear(all_clear_a));

  pipe_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .RST_IDX(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .all_clear(all_clear_b));

  typedef struct {
    string       name;
    bit          dut_b;
    int          port;
    logic [31:0] data;
    logic        busy;
    logic        aclr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic push1(input string nm, input bit b, input int k,
                       input logic [31:0] d, input logic bsy, input logic ac);
    exp_t e;
    e.name = nm; e.dut_b = b; e.port = k; e.data = d; e.busy = bsy; e.aclr = ac;
    sb_q.push_back(e);
  endtask

  // Same port on both instances with per-instance data.
  task automatic push2(input string nm, input int k, input logic [31:0] da,
                       input logic [31:0] db, input logic bsy, input logic ac);
    push1({nm, "_a"}, 1'b0, k, da, bsy, ac);
    push1({nm, "_b"}, 1'b1, k, db, bsy, ac);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Monitor: compares every queued expectation against the outputs at negedge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ad;
    logic        ab, aa;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut_b) begin
        ad = rd_data_b[e.port*XLEN +: XLEN]; ab = rd_busy_b[e.port]; aa = all_clear_b;
      end else begin
        ad = rd_data_a[e.port*XLEN +: XLEN]; ab = rd_busy_a[e.port]; aa = all_clear_a;
      end
      n_checks++;
      if ({ad, ab, aa} !== {e.data, e.busy, e.aclr}) begin
        n_errors++;
        $display("FAIL %s port%0d: got data=%h busy=%b all_clear=%b, want data=%h busy=%b all_clear=%b",
                 e.name, e.port, ad, ab, aa, e.data, e.busy, e.aclr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset asserted mid-cycle; checked while held low.
    #7 rst_n = 1'b0;
    set_rd(5'd0, 5'd5);
    push2("rst_r0", 0, 32'd0, 32'd0, 1'b0, 1'b1);
    push2("rst_r5", 1, 32'd5, 32'd0, 1'b0, 1'b1);
    step();
    set_rd(5'd31, 5'd5);
    push2("rst_r31", 0, 32'd31, 32'd0, 1'b0, 1'b1);
    @(negedge clk); #1 rst_n = 1'b1;

    // 2: write r7, read it back on both ports.
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; set_rd(5'd7, 5'd7);
    push2("wr7_same", 0, BYP ? 32'hDEADBEEF : 32'd7, BYP ? 32'hDEADBEEF : 32'd0, 1'b0, 1'b1);
    step();
    wr_en = 1'b0;
    push2("rd7_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    push2("rd7_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);

    // 3: writes and reservations to r0 are ignored.
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    push2("x0_same", 0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    push2("x0_after", 0, 32'd0, 32'd0, 1'b0, 1'b1);
    push2("x0_after", 1, 32'd0, 32'd0, 1'b0, 1'b1);

    // 4: scoreboard on r3.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; set_rd(5'd3, 5'd3);
    push2("rsv3_pre", 0, 32'd3, 32'd0, 1'b0, 1'b1);
    step();
    rsv_en = 1'b0;
    push2("rsv3_busy", 0, 32'd3, 32'd0, 1'b1, 1'b0);
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd3;
    push2("wr_rsv3_same", 1, BYP ? 32'h55 : 32'd3, BYP ? 32'h55 : 32'd0, !BYP, 1'b0);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    push2("wr_rsv3_after", 0, 32'h55, 32'h55, 1'b1, 1'b0);
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    push2("wr3_same", 0, 32'h55, 32'h55, !BYP, 1'b0);
    step();
    wr_en = 1'b0;
    push2("wr3_clear", 1, 32'h55, 32'h55, 1'b0, 1'b1);

    // 5: write-through behaviour on r9; port 1 keeps reading r7.
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5; set_rd(5'd9, 5'd7);
    push2("byp9_same", 0, BYP ? 32'hA5A5 : 32'd9, BYP ? 32'hA5A5 : 32'd0, 1'b0, 1'b1);
    push2("byp9_p1_r7", 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    step();
    wr_en = 1'b0;
    push2("byp9_next", 0, 32'hA5A5, 32'hA5A5, 1'b0, 1'b1);

    // 6: r4 busy holding 0x77, then reset pulsed between edges.
    step();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd4;
    set_rd(5'd4, 5'd9);
    step();
    wr_en = 1'b0; rsv_en = 1'b0;
    push2("r4_busy", 0, 32'h77, 32'h77, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    push2("rst_mid_r4", 0, 32'd4, 32'd0, 1'b0, 1'b1);
    push2("rst_mid_r9", 1, 32'd9, 32'd0, 1'b0, 1'b1);
    @(negedge clk); #1 rst_n = 1'b1;
    step();
    push2("post_rst_r4", 0, 32'd4, 32'd0, 1'b0, 1'b1);

    step();
    step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
